// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA geometry macros, arbiter state type and pixel helpers.
// Geometry macros may be overridden on the command line before this file.
`ifndef VGA_COLS
`define VGA_COLS 20
`endif
`ifndef VGA_ROWS
`define VGA_ROWS 12
`endif
`ifndef VGA_H_BITS
`define VGA_H_BITS 5
`endif
`ifndef VGA_V_BITS
`define VGA_V_BITS 4
`endif
`ifndef BYTE_BITS
`define BYTE_BITS 8
`endif

package vga_pkg;

  localparam int VGA_H_W    = `VGA_H_BITS;
  localparam int VGA_V_W    = `VGA_V_BITS;
  localparam int VGA_PIXELS = `VGA_COLS * `VGA_ROWS;

  localparam logic [VGA_H_W-1:0] VGA_X_LAST = VGA_H_W'(`VGA_COLS - 1);
  localparam logic [VGA_V_W-1:0] VGA_Y_LAST = VGA_V_W'(`VGA_ROWS - 1);

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } arb_state_t;

  function automatic logic pix_in_range(input logic [VGA_H_W-1:0] x,
                                        input logic [VGA_V_W-1:0] y);
    return (x <= VGA_X_LAST) && (y <= VGA_Y_LAST);
  endfunction

endpackage

// File: rtl/VgaRasterCounter.sv
// rtl/VgaRasterCounter.sv - raster-order x/y counter with explicit wrap and last-pixel flag.
// Shared with the display scanner; wraps by compare, never by overflow.
module VgaRasterCounter
  import vga_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  output logic [VGA_H_W-1:0] x,
  output logic [VGA_V_W-1:0] y,
  output logic               last
);

  logic x_wrap;
  logic y_wrap;

  assign x_wrap = (x == VGA_X_LAST);
  assign y_wrap = (y == VGA_Y_LAST);
  assign last   = x_wrap && y_wrap;

  always_ff @(posedge clk) begin
    if (!reset) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      if (x_wrap) begin
        x <= '0;
        y <= y_wrap ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_buf_wr_arb.sv
// rtl/vga_buf_wr_arb.sv - two-requester frame-buffer write arbiter with full-buffer clear sweep.
// VGA_ARB_RR_EN selects round-robin arbitration; default is fixed priority A over B.
module vga_buf_wr_arb
  import vga_pkg::*;
#(
  parameter logic [`BYTE_BITS-1:0] CLEAR_BYTE = 8'h00
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   a_valid,
  input  logic [`VGA_H_BITS-1:0] a_x,
  input  logic [`VGA_V_BITS-1:0] a_y,
  input  logic [`BYTE_BITS-1:0]  a_byte,
  output logic                   a_ready,
  input  logic                   b_valid,
  input  logic [`VGA_H_BITS-1:0] b_x,
  input  logic [`VGA_V_BITS-1:0] b_y,
  input  logic [`BYTE_BITS-1:0]  b_byte,
  output logic                   b_ready,
  input  logic                   clear_req,
  output logic                   clear_busy,
  output logic                   clear_done,
  output logic                   wr_en,
  output logic [`VGA_H_BITS-1:0] wr_x,
  output logic [`VGA_V_BITS-1:0] wr_y,
  output logic [`BYTE_BITS-1:0]  wr_byte
);

  arb_state_t         state;
  arb_state_t         state_nxt;
  logic               grant_a;
  logic               grant_b;
  logic               sweep_issue;
  logic [VGA_H_W-1:0] cnt_x;
  logic [VGA_V_W-1:0] cnt_y;
  logic               cnt_last;

`ifdef VGA_ARB_RR_EN
  logic favour_b;

  always_ff @(posedge clk) begin
    if (!reset) begin
      favour_b <= 1'b0;
    end else if (grant_a) begin
      favour_b <= 1'b1;
    end else if (grant_b) begin
      favour_b <= 1'b0;
    end
  end
`endif

  // CLEAR stays for the clear_done cycle so requesters see ready only once ARB is back.
  always_comb begin
    state_nxt   = state;
    grant_a     = 1'b0;
    grant_b     = 1'b0;
    sweep_issue = 1'b0;
    case (state)
      ARB: begin
        if (clear_req) begin
          state_nxt = CLEAR;
        end else begin
`ifdef VGA_ARB_RR_EN
          if (a_valid && (!b_valid || !favour_b)) begin
            grant_a = 1'b1;
          end else if (b_valid) begin
            grant_b = 1'b1;
          end
`else
          if (a_valid) begin
            grant_a = 1'b1;
          end else if (b_valid) begin
            grant_b = 1'b1;
          end
`endif
        end
      end
      CLEAR: begin
        if (clear_done) begin
          state_nxt = ARB;
        end else begin
          sweep_issue = 1'b1;
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ARB;
    end else begin
      state <= state_nxt;
    end
  end

  VgaRasterCounter u_raster (
    .clk   (clk),
    .reset (reset),
    .en    (sweep_issue),
    .x     (cnt_x),
    .y     (cnt_y),
    .last  (cnt_last)
  );

  assign a_ready    = grant_a;
  assign b_ready    = grant_b;
  assign clear_busy = (state == CLEAR);

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_en      <= 1'b0;
      wr_x       <= '0;
      wr_y       <= '0;
      wr_byte    <= '0;
      clear_done <= 1'b0;
    end else if (sweep_issue) begin
      wr_en      <= 1'b1;
      wr_x       <= cnt_x;
      wr_y       <= cnt_y;
      wr_byte    <= CLEAR_BYTE;
      clear_done <= cnt_last;
    end else if (grant_a) begin
      wr_en      <= pix_in_range(a_x, a_y);
      wr_x       <= a_x;
      wr_y       <= a_y;
      wr_byte    <= a_byte;
      clear_done <= 1'b0;
    end else if (grant_b) begin
      wr_en      <= pix_in_range(b_x, b_y);
      wr_x       <= b_x;
      wr_y       <= b_y;
      wr_byte    <= b_byte;
      clear_done <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      clear_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_buf_wr_arb.sv
// tb/tb_vga_buf_wr_arb.sv - self-checking bench for vga_buf_wr_arb (directed plus randomized).
`ifndef VGA_COLS
`define VGA_COLS 20
`endif
`ifndef VGA_ROWS
`define VGA_ROWS 12
`endif
`ifndef VGA_H_BITS
`define VGA_H_BITS 5
`endif
`ifndef VGA_V_BITS
`define VGA_V_BITS 4
`endif
`ifndef BYTE_BITS
`define BYTE_BITS 8
`endif

module tb_vga_buf_wr_arb;
  import vga_pkg::*;

  localparam int COLS   = `VGA_COLS;
  localparam int ROWS   = `VGA_ROWS;
  localparam int HB     = `VGA_H_BITS;
  localparam int VB     = `VGA_V_BITS;
  localparam int PIXELS = COLS * ROWS;
`ifdef VGA_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   a_valid = 1'b0, b_valid = 1'b0, clear_req = 1'b0;
  logic [`VGA_H_BITS-1:0] a_x = '0, b_x = '0;
  logic [`VGA_V_BITS-1:0] a_y = '0, b_y = '0;
  logic [`BYTE_BITS-1:0]  a_byte = '0, b_byte = '0;
  logic                   a_ready, b_ready, clear_busy, clear_done, wr_en;
  logic [`VGA_H_BITS-1:0] wr_x;
  logic [`VGA_V_BITS-1:0] wr_y;
  logic [`BYTE_BITS-1:0]  wr_byte;

  int n_checks = 0;
  int n_pass   = 0;

  vga_buf_wr_arb dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_x(a_x), .a_y(a_y), .a_byte(a_byte), .a_ready(a_ready),
    .b_valid(b_valid), .b_x(b_x), .b_y(b_y), .b_byte(b_byte), .b_ready(b_ready),
    .clear_req(clear_req), .clear_busy(clear_busy), .clear_done(clear_done),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_byte(wr_byte)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; b_valid = 1'b0; clear_req = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Clear sweep with held out-of-range requester A, optional mid-sweep re-pulse or reset.
  task automatic sweep(input string nm, input int repulse_at, input int reset_at);
    int k = 0;
    int done_cnt = 0;
    int gaps = 0;
    bit past_done = 1'b0;
    bit done_now;
    bit fin = 1'b0;
    a_valid = 1'b1; a_x = HB'(COLS); a_y = '0; a_byte = 8'hEE;
    clear_req = 1'b1;
    @(negedge clk);
    chk({nm, "_clr_wins_a_ready"}, 32'(a_ready), 32'd0);
    tick();
    clear_req = 1'b0;
    chk({nm, "_busy_entered"}, 32'(clear_busy), 32'd1);
    for (int c = 0; c < PIXELS + 20 && !fin; c++) begin
      clear_req = 1'b0;
      done_now = clear_done;
      if (wr_en) begin
        if (k < PIXELS) begin
          chk({nm, "_x"}, 32'(wr_x), 32'(k % COLS));
          chk({nm, "_y"}, 32'(wr_y), 32'(k / COLS));
          chk({nm, "_byte"}, 32'(wr_byte), 32'h00);
          chk({nm, "_done_pos"}, 32'(clear_done), 32'(k == PIXELS - 1));
        end
        k++;
      end else if (k > 0 && k < PIXELS && !past_done) begin
        gaps++;
      end
      if (clear_done) done_cnt++;
      if (k == repulse_at) clear_req = 1'b1;
      if (reset_at >= 0 && k == reset_at) begin
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk({nm, "_rst_wr_en"}, 32'(wr_en), 32'd0);
        chk({nm, "_rst_done"}, 32'(clear_done), 32'd0);
        chk({nm, "_rst_busy"}, 32'(clear_busy), 32'd0);
        @(negedge clk);
        chk({nm, "_rst_arb_ready"}, 32'(a_ready), 32'd1);
        tick();
        chk({nm, "_rst_no_done"}, 32'(clear_done), 32'd0);
        chk({nm, "_rst_no_write"}, 32'(wr_en), 32'd0);
        idle_inputs();
        tick();
        return;
      end
      @(negedge clk);
      chk({nm, "_a_ready"}, 32'(a_ready), 32'(past_done));
      chk({nm, "_busy"}, 32'(clear_busy), 32'(!past_done));
      if (past_done) fin = 1'b1;
      if (done_now) past_done = 1'b1;
      if (!fin) tick();
    end
    chk({nm, "_finished"}, 32'(fin), 32'd1);
    chk({nm, "_write_count"}, 32'(k), 32'(PIXELS));
    chk({nm, "_done_count"}, 32'(done_cnt), 32'd1);
    chk({nm, "_gaps"}, 32'(gaps), 32'd0);
    idle_inputs();
    tick();
  endtask

  initial begin
    bit fav_b;
    bit ga, gb, exp_en;
    int ex, ey, eb;

    do_reset();
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_x", 32'(wr_x), 32'd0);
    chk("rst_wr_y", 32'(wr_y), 32'd0);
    chk("rst_wr_byte", 32'(wr_byte), 32'd0);
    chk("rst_busy", 32'(clear_busy), 32'd0);
    chk("rst_done", 32'(clear_done), 32'd0);

    a_valid = 1'b1; a_x = 3; a_y = 2; a_byte = 8'h5A;
    @(negedge clk);
    chk("basic_a_ready", 32'(a_ready), 32'd1);
    chk("basic_b_ready", 32'(b_ready), 32'd0);
    tick();
    a_valid = 1'b0;
    chk("basic_wr_en", 32'(wr_en), 32'd1);
    chk("basic_wr_x", 32'(wr_x), 32'd3);
    chk("basic_wr_y", 32'(wr_y), 32'd2);
    chk("basic_wr_byte", 32'(wr_byte), 32'h5A);

    do_reset();
    a_valid = 1'b1; a_x = 1; a_y = 1; a_byte = 8'h11;
    b_valid = 1'b1; b_x = 2; b_y = 2; b_byte = 8'h22;
    for (int i = 0; i < 4; i++) begin
      ga = RR ? (i % 2 == 0) : 1'b1;
      @(negedge clk);
      chk("both_a_ready", 32'(a_ready), 32'(ga));
      chk("both_b_ready", 32'(b_ready), 32'(!ga));
      tick();
      chk("both_wr_byte", 32'(wr_byte), ga ? 32'h11 : 32'h22);
    end
    idle_inputs();
    tick();

    a_valid = 1'b1; a_x = HB'(COLS); a_y = 0; a_byte = 8'h33;
    @(negedge clk);
    chk("oob_x_ready", 32'(a_ready), 32'd1);
    tick();
    a_valid = 1'b0;
    chk("oob_x_wr_en", 32'(wr_en), 32'd0);
    b_valid = 1'b1; b_x = 0; b_y = VB'(ROWS); b_byte = 8'h44;
    @(negedge clk);
    chk("oob_y_ready", 32'(b_ready), 32'd1);
    tick();
    b_valid = 1'b0;
    chk("oob_y_wr_en", 32'(wr_en), 32'd0);
    a_valid = 1'b1; a_x = HB'(COLS - 1); a_y = VB'(ROWS - 1); a_byte = 8'h55;
    tick();
    a_valid = 1'b0;
    chk("corner_wr_en", 32'(wr_en), 32'd1);
    chk("corner_wr_x", 32'(wr_x), 32'(COLS - 1));
    chk("corner_wr_y", 32'(wr_y), 32'(ROWS - 1));
    tick();

    sweep("sweep", -1, -1);
    sweep("repulse", 50, -1);
    sweep("abort", -1, 10);

    do_reset();
    fav_b = 1'b0;
    repeat (400) begin
      a_valid = 1'($urandom_range(0, 1));
      b_valid = 1'($urandom_range(0, 1));
      a_x = HB'($urandom_range(0, COLS + 3));
      a_y = VB'($urandom_range(0, ROWS + 3));
      b_x = HB'($urandom_range(0, COLS + 3));
      b_y = VB'($urandom_range(0, ROWS + 3));
      a_byte = 8'($urandom);
      b_byte = 8'($urandom);
      if (a_valid && b_valid) begin
        ga = !(RR && fav_b);
        gb = !ga;
      end else begin
        ga = a_valid;
        gb = b_valid;
      end
      @(negedge clk);
      chk("rand_a_ready", 32'(a_ready), 32'(ga));
      chk("rand_b_ready", 32'(b_ready), 32'(gb));
      ex = ga ? int'(a_x) : int'(b_x);
      ey = ga ? int'(a_y) : int'(b_y);
      eb = ga ? int'(a_byte) : int'(b_byte);
      exp_en = (ga || gb) && ex < COLS && ey < ROWS;
      if (ga) fav_b = 1'b1;
      else if (gb) fav_b = 1'b0;
      tick();
      chk("rand_wr_en", 32'(wr_en), 32'(exp_en));
      if (exp_en) begin
        chk("rand_wr_x", 32'(wr_x), 32'(ex));
        chk("rand_wr_y", 32'(wr_y), 32'(ey));
        chk("rand_wr_byte", 32'(wr_byte), 32'(eb));
      end
    end
    idle_inputs();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
